// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_pkg;

  // All segments off (active-low bus).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Scan FSM: anodes off during the guard part of a slot, one anode on during drive.
  // The ST_ prefix keeps these names clear of the GUARD timing parameter.
  typedef enum logic {
    ST_GUARD = 1'b0,
    ST_DRIVE = 1'b1
  } scan_state_e;

  // One register-file entry per digit.
  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       blink;
  } digit_entry_t;

  // Digits come out of reset dark, showing 0, not blinking.
  localparam digit_entry_t DIGIT_RESET = '{value: 4'h0, blank: 1'b1, blink: 1'b0};

endpackage

// File: rtl/seg_scan_ctrl_seven_seg.sv
// Combinational hex to seven-segment decoder, active-low {g,f,e,d,c,b,a}.
module seg_scan_ctrl_seven_seg (
  input  logic [3:0] value,
  output logic [6:0] seg_n
);

  // Full hex glyph table; lowercase b and d keep them distinct from 8 and 0.
  always_comb begin
    seg_n = 7'b1111111;
    case (value)
      4'h0: seg_n = 7'b1000000;
      4'h1: seg_n = 7'b1111001;
      4'h2: seg_n = 7'b0100100;
      4'h3: seg_n = 7'b0110000;
      4'h4: seg_n = 7'b0011001;
      4'h5: seg_n = 7'b0010010;
      4'h6: seg_n = 7'b0000010;
      4'h7: seg_n = 7'b1011000;
      4'h8: seg_n = 7'b0000000;
      4'h9: seg_n = 7'b0010000;
      4'hA: seg_n = 7'b0001000;
      4'hB: seg_n = 7'b0000011;
      4'hC: seg_n = 7'b1000110;
      4'hD: seg_n = 7'b0100001;
      4'hE: seg_n = 7'b0000110;
      4'hF: seg_n = 7'b0001110;
      default: seg_n = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits on one
// shared segment bus, with a per-digit register file loaded over valid/ready.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int GUARD      = 500,
  parameter int BLINK_DIV  = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [2:0]            wr_digit,
  input  logic [3:0]            wr_value,
  input  logic                  wr_blank,
  input  logic                  wr_blink,
  output logic                  wr_err,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [6:0]            seg_n
);

  localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DIGIT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int FRAME_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  GUARD_LAST = SLOT_W'(GUARD - 1);
  localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_DIV - 1);
  localparam logic [3:0]         DIGIT_CNT  = 4'(NUM_DIGITS);

  logic [SLOT_W-1:0]  slot_cnt_reg;
  logic [DIGIT_W-1:0] cur_digit_reg;
  logic [FRAME_W-1:0] frame_cnt_reg;
  logic               blink_phase_reg;
  scan_state_e        state_reg;

  digit_entry_t       entry_reg [NUM_DIGITS];

  logic [NUM_DIGITS-1:0] an_n_reg;
  logic [6:0]            seg_n_reg;
  logic                  wr_err_reg;

  logic                  slot_wrap;
  logic                  frame_wrap;
  logic                  wr_in_range;
  logic                  wr_hits_cur;
  logic                  wr_fire;
  digit_entry_t          cur_entry;
  logic                  cur_dark;
  logic [6:0]            dec_seg_n;
  logic [NUM_DIGITS-1:0] an_drive;

  assign slot_wrap  = (slot_cnt_reg == SLOT_LAST);
  assign frame_wrap = slot_wrap && (cur_digit_reg == DIGIT_LAST);

  // A write may land anywhere except on the digit currently lit, so the
  // driven glyph never changes mid-slot. Out-of-range indices are always
  // accepted and dropped.
  assign wr_in_range = ({1'b0, wr_digit} < DIGIT_CNT);
  assign wr_hits_cur = (wr_digit == 3'(cur_digit_reg));
  assign wr_ready    = (state_reg == ST_GUARD) || !wr_hits_cur;
  assign wr_fire     = wr_valid && wr_ready;

  assign cur_entry = entry_reg[cur_digit_reg];
  assign cur_dark  = cur_entry.blank || (cur_entry.blink && blink_phase_reg);

  // Active-low one-hot anode pattern for the current digit.
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      assign an_drive[gi] = (cur_digit_reg != DIGIT_W'(gi));
    end
  endgenerate

  // Single shared decoder, fed by whichever digit owns the current slot.
  seg_scan_ctrl_seven_seg u_dec (
    .value (cur_entry.value),
    .seg_n (dec_seg_n)
  );

  // Slot, digit, frame and blink-phase timebase; free-running, never stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt_reg    <= '0;
      cur_digit_reg   <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      if (slot_wrap) begin
        slot_cnt_reg  <= '0;
        cur_digit_reg <= (cur_digit_reg == DIGIT_LAST) ? '0 : cur_digit_reg + DIGIT_W'(1);
      end else begin
        slot_cnt_reg  <= slot_cnt_reg + SLOT_W'(1);
      end
      if (frame_wrap) begin
        if (frame_cnt_reg == FRAME_LAST) begin
          frame_cnt_reg   <= '0;
          blink_phase_reg <= ~blink_phase_reg;
        end else begin
          frame_cnt_reg   <= frame_cnt_reg + FRAME_W'(1);
        end
      end
    end
  end

  // Scan FSM: guard for the first GUARD cycles of a slot, drive for the rest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_GUARD;
    end else begin
      case (state_reg)
        ST_GUARD: if (slot_cnt_reg == GUARD_LAST) state_reg <= ST_DRIVE;
        ST_DRIVE: if (slot_wrap) state_reg <= ST_GUARD;
        default:  state_reg <= ST_GUARD;
      endcase
    end
  end

  // Register file: accepted in-range writes update the addressed entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        entry_reg[i] <= DIGIT_RESET;
      end
    end else if (wr_fire && wr_in_range) begin
      entry_reg[wr_digit] <= '{value: wr_value, blank: wr_blank, blink: wr_blink};
    end
  end

  // Registered display and error outputs, one cycle behind the FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_n_reg   <= '1;
      seg_n_reg  <= SEG_BLANK;
      wr_err_reg <= 1'b0;
    end else begin
      wr_err_reg <= wr_fire && !wr_in_range;
      if (state_reg == ST_DRIVE) begin
        an_n_reg  <= an_drive;
        seg_n_reg <= cur_dark ? SEG_BLANK : dec_seg_n;
      end else begin
        an_n_reg  <= '1;
        seg_n_reg <= SEG_BLANK;
      end
    end
  end

  assign an_n   = an_n_reg;
  assign seg_n  = seg_n_reg;
  assign wr_err = wr_err_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with NUM_DIGITS=4, SCAN_DIV=8, GUARD=2, BLINK_DIV=2.
module tb_seg_scan_ctrl;

  localparam logic [6:0] S_0 = 7'b1000000;
  localparam logic [6:0] S_1 = 7'b1111001;
  localparam logic [6:0] S_3 = 7'b0110000;
  localparam logic [6:0] S_5 = 7'b0010010;
  localparam logic [6:0] S_7 = 7'b1011000;
  localparam logic [6:0] S_9 = 7'b0010000;
  localparam logic [6:0] S_A = 7'b0001000;
  localparam logic [6:0] S_E = 7'b0000110;
  localparam logic [6:0] S_OFF = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_valid = 1'b0;
  logic       wr_ready;
  logic [2:0] wr_digit = 3'd0;
  logic [3:0] wr_value = 4'd0;
  logic       wr_blank = 1'b0;
  logic       wr_blink = 1'b0;
  logic       wr_err;
  logic [3:0] an_n;
  logic [6:0] seg_n;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg_scan_ctrl #(
    .NUM_DIGITS (4),
    .SCAN_DIV   (8),
    .GUARD      (2),
    .BLINK_DIV  (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_digit (wr_digit),
    .wr_value (wr_value),
    .wr_blank (wr_blank),
    .wr_blink (wr_blink),
    .wr_err   (wr_err),
    .an_n     (an_n),
    .seg_n    (seg_n)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, observed time %0t required < 1000000", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %b required %b", tag, cyc, obs, exp);
    end
  endtask

  // Advance to the negedge where cyc % 32 == m (bounded).
  task automatic wait_mod(input int m);
    int n = 0;
    while ((cyc % 32) != m && n < 80) begin
      @(negedge clk);
      n++;
    end
    chk("wait_mod_reached", 8'((cyc % 32) == m), 8'd1);
  endtask

  // Expected outputs for this cycle: output k shows the state after edge k-1.
  task automatic check_cycle(input logic [3:0][6:0] lit, input logic [3:0] blank,
                             input logic [3:0] blink);
    int k, pos, d, ph;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    k   = cyc;
    pos = (k - 1) % 8;
    d   = ((k - 1) / 8) % 4;
    ph  = ((k - 1) / 64) % 2;
    exp_an  = 4'b1111;
    exp_seg = S_OFF;
    if (pos >= 2) begin
      exp_an = ~(4'b0001 << d);
      if (!(blank[d] || (blink[d] && ph == 1))) exp_seg = lit[d];
    end
    chk("an_n", {4'b0, an_n}, {4'b0, exp_an});
    chk("seg_n", {1'b0, seg_n}, {1'b0, exp_seg});
  endtask

  task automatic check_frame(input logic [3:0][6:0] lit, input logic [3:0] blank,
                             input logic [3:0] blink);
    wait_mod(0);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      check_cycle(lit, blank, blink);
    end
    $display("frame ending cyc %0d checked", cyc);
  endtask

  task automatic do_write(input logic [2:0] d, input logic [3:0] v, input logic bl,
                          input logic bk);
    int waited = 0;
    @(negedge clk);
    wr_digit = d; wr_value = v; wr_blank = bl; wr_blink = bk; wr_valid = 1'b1;
    #1;
    while (!wr_ready && waited < 20) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("write_ready", {7'b0, wr_ready}, 8'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    $display("write digit=%0d value=%h blank=%0d blink=%0d at cyc %0d", d, v, bl, bk, cyc);
  endtask

  initial begin
    // Power-on reset.
    #1 rst = 1'b1;
    #2;
    chk("reset_an_n", {4'b0, an_n}, 8'h0F);
    chk("reset_seg_n", {1'b0, seg_n}, 8'h7F);
    chk("reset_wr_err", {7'b0, wr_err}, 8'd0);
    chk("reset_wr_ready", {7'b0, wr_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // All digits dark after reset, but anodes still scan.
    check_frame({S_0, S_0, S_0, S_0}, 4'b1111, 4'b0000);

    // Basic scan: 5, 9, E, 1.
    do_write(3'd0, 4'h5, 1'b0, 1'b0);
    do_write(3'd1, 4'h9, 1'b0, 1'b0);
    do_write(3'd2, 4'hE, 1'b0, 1'b0);
    do_write(3'd3, 4'h1, 1'b0, 1'b0);
    check_frame({S_1, S_E, S_9, S_5}, 4'b0000, 4'b0000);

    // Stall: digit 0 is being driven at cyc%32 == 4.
    wait_mod(4);
    wr_digit = 3'd1; wr_valid = 1'b0;
    #1 chk("ready_other_digit", {7'b0, wr_ready}, 8'd1);
    wr_digit = 3'd0; wr_value = 4'h7; wr_blank = 1'b0; wr_blink = 1'b0; wr_valid = 1'b1;
    #1 chk("stall_ready_c4", {7'b0, wr_ready}, 8'd0);
    for (int i = 5; i < 8; i++) begin
      @(negedge clk);
      chk("stall_ready", {7'b0, wr_ready}, 8'd0);
    end
    @(negedge clk);
    chk("stall_release_ready", {7'b0, wr_ready}, 8'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    $display("write digit=0 value=7 accepted after stall at cyc %0d", cyc);
    check_frame({S_1, S_E, S_9, S_7}, 4'b0000, 4'b0000);

    // Blink on digit 1: lit for two frames, dark for two.
    do_write(3'd1, 4'h3, 1'b0, 1'b1);
    for (int f = 0; f < 4; f++) begin
      check_frame({S_1, S_E, S_3, S_7}, 4'b0000, 4'b0010);
    end

    // Out-of-range write: accepted, flagged for one cycle, dropped.
    @(negedge clk);
    wr_digit = 3'd5; wr_value = 4'h8; wr_blank = 1'b0; wr_blink = 1'b0; wr_valid = 1'b1;
    #1 chk("err_ready", {7'b0, wr_ready}, 8'd1);
    chk("err_before", {7'b0, wr_err}, 8'd0);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    $display("write digit=5 value=8 (out of range) at cyc %0d", cyc);
    @(negedge clk);
    chk("err_pulse", {7'b0, wr_err}, 8'd1);
    @(negedge clk);
    chk("err_cleared", {7'b0, wr_err}, 8'd0);
    check_frame({S_1, S_E, S_3, S_7}, 4'b0000, 4'b0010);

    // Boundary: write digit 3 on the last cycle of digit 2's slot.
    wait_mod(23);
    wr_digit = 3'd3; wr_value = 4'hA; wr_blank = 1'b0; wr_blink = 1'b0; wr_valid = 1'b1;
    #1 chk("boundary_ready", {7'b0, wr_ready}, 8'd1);
    @(posedge clk);
    #1 wr_valid = 1'b0;
    $display("write digit=3 value=A at slot wrap, cyc %0d", cyc);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_cycle({S_A, S_E, S_3, S_7}, 4'b0000, 4'b0010);
    end

    // Asynchronous reset in the middle of digit 2's drive.
    wait_mod(20);
    check_cycle({S_A, S_E, S_3, S_7}, 4'b0000, 4'b0010);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_an_n", {4'b0, an_n}, 8'h0F);
    chk("async_rst_seg_n", {1'b0, seg_n}, 8'h7F);
    chk("async_rst_wr_err", {7'b0, wr_err}, 8'd0);
    chk("async_rst_wr_ready", {7'b0, wr_ready}, 8'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_frame({S_0, S_0, S_0, S_0}, 4'b1111, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
